// File: rtl/wvb_rr_arbiter.sv
// N-channel arbiter between per-channel waveform buffers and one downstream consumer.
// Grants one channel per event (round-robin or fixed priority), latches its tagged header and steers data access.
module wvb_rr_arbiter #(
  parameter int unsigned N_CHANNELS       = 24,
  parameter int unsigned P_CHAN_IDX_WIDTH = 5,
  parameter int unsigned P_DATA_WIDTH     = 170,
  parameter int unsigned P_HDR_WIDTH      = 80,
  parameter int unsigned P_CNT_WIDTH      = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     prio_mode,
  input  logic [N_CHANNELS-1:0]                    chan_mask,
  input  logic [N_CHANNELS-1:0]                    wvb_hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]        wvb_hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0]       wvb_data,
  output logic [N_CHANNELS-1:0]                    wvb_hdr_rdreq,
  output logic [N_CHANNELS-1:0]                    wvb_rdreq,
  output logic [N_CHANNELS-1:0]                    wvb_rddone,
  output logic                                     out_hdr_valid,
  output logic [P_CHAN_IDX_WIDTH+P_HDR_WIDTH-1:0]  out_hdr_data,
  output logic [P_DATA_WIDTH-1:0]                  out_data,
  input  logic                                     out_rdreq,
  input  logic                                     out_rddone,
  output logic                                     busy,
  output logic [P_CHAN_IDX_WIDTH-1:0]              cur_chan,
  output logic [P_CNT_WIDTH-1:0]                   evt_cnt
);

  localparam int unsigned CW = P_CHAN_IDX_WIDTH;
  localparam int unsigned HW = P_HDR_WIDTH;
  localparam int unsigned DW = P_DATA_WIDTH;
  localparam logic [N_CHANNELS-1:0] CHAN_ONE = N_CHANNELS'(1);
  localparam logic [CW-1:0] LAST_CHAN_RST = CW'(N_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cur_chan_q, cur_chan_d;
  logic [CW-1:0]         last_chan_q, last_chan_d;
  logic [N_CHANNELS-1:0] hdr_rdreq_q, hdr_rdreq_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [CW+HW-1:0]      hdr_data_q, hdr_data_d;
  logic [P_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

  logic [N_CHANNELS-1:0] req_c;
  logic                  lo_found_c, hi_found_c;
  logic [CW-1:0]         lo_sel_c, hi_sel_c, sel_c;
  logic                  grant_c;
  logic [N_CHANNELS-1:0] chan_oh_c;
  logic [HW-1:0]         hdr_mux_c;
  logic [DW-1:0]         data_mux_c;

  assign req_c = ~wvb_hdr_empty & chan_mask;

  // Descending scan: lowest requester overall, and lowest requester above last_chan.
  always_comb begin
    lo_found_c = 1'b0;
    lo_sel_c   = '0;
    hi_found_c = 1'b0;
    hi_sel_c   = '0;
    for (int i = int'(N_CHANNELS) - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        lo_found_c = 1'b1;
        lo_sel_c   = CW'(i);
        if (i > int'(last_chan_q)) begin
          hi_found_c = 1'b1;
          hi_sel_c   = CW'(i);
        end
      end
    end
  end

  // Round-robin wraps to the lowest requester when nothing lies above last_chan.
  assign sel_c   = (prio_mode || !hi_found_c) ? lo_sel_c : hi_sel_c;
  assign grant_c = en && lo_found_c;

  assign chan_oh_c = CHAN_ONE << cur_chan_q;

  always_comb begin
    hdr_mux_c  = '0;
    data_mux_c = '0;
    for (int i = 0; i < int'(N_CHANNELS); i++) begin
      if (CW'(i) == cur_chan_q) begin
        hdr_mux_c  = wvb_hdr_data[i*HW +: HW];
        data_mux_c = wvb_data[i*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_c) state_d = ST_HDR;
      ST_HDR:  state_d = ST_XFER;
      ST_XFER: if (out_rddone) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of registered outputs plus the combinational data path
  always_comb begin
    cur_chan_d  = cur_chan_q;
    last_chan_d = last_chan_q;
    hdr_rdreq_d = '0;
    hdr_valid_d = hdr_valid_q;
    hdr_data_d  = hdr_data_q;
    evt_cnt_d   = evt_cnt_q;
    wvb_rdreq   = '0;
    wvb_rddone  = '0;
    out_data    = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          cur_chan_d  = sel_c;
          hdr_rdreq_d = CHAN_ONE << sel_c;
        end
      end
      ST_HDR: begin
        hdr_data_d  = {cur_chan_q, hdr_mux_c};
        hdr_valid_d = 1'b1;
      end
      ST_XFER: begin
        out_data = data_mux_c;
        if (out_rdreq) wvb_rdreq = chan_oh_c;
        if (out_rddone) begin
          wvb_rddone  = chan_oh_c;
          hdr_valid_d = 1'b0;
          evt_cnt_d   = evt_cnt_q + P_CNT_WIDTH'(1);
          last_chan_d = cur_chan_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_chan_q  <= '0;
      last_chan_q <= LAST_CHAN_RST;
      hdr_rdreq_q <= '0;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      evt_cnt_q   <= '0;
    end else begin
      cur_chan_q  <= cur_chan_d;
      last_chan_q <= last_chan_d;
      hdr_rdreq_q <= hdr_rdreq_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_data_q  <= hdr_data_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  assign wvb_hdr_rdreq = hdr_rdreq_q;
  assign out_hdr_valid = hdr_valid_q;
  assign out_hdr_data  = hdr_data_q;
  assign busy          = (state_q != ST_IDLE);
  assign cur_chan      = cur_chan_q;
  assign evt_cnt       = evt_cnt_q;

endmodule

// File: tb/tb_wvb_rr_arbiter.sv
// Directed bench for wvb_rr_arbiter: header FIFOs modelled as push/pop counters per channel.
module tb_wvb_rr_arbiter;

  localparam int N    = 24;
  localparam int CW   = 5;
  localparam int DW   = 170;
  localparam int HW   = 80;
  localparam int CNTW = 32;

  logic               clk = 1'b0;
  logic               rst, en, prio_mode;
  logic [N-1:0]       chan_mask, wvb_hdr_empty;
  logic [N*HW-1:0]    wvb_hdr_data;
  logic [N*DW-1:0]    wvb_data;
  logic [N-1:0]       wvb_hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic               out_hdr_valid, out_rdreq, out_rddone, busy;
  logic [CW+HW-1:0]   out_hdr_data;
  logic [DW-1:0]      out_data;
  logic [CW-1:0]      cur_chan;
  logic [CNTW-1:0]    evt_cnt;

  int pushed[N];
  int popped[N];
  int checks = 0;
  int errors = 0;
  int exp_evt = 0;
  logic [CW+HW-1:0] last_exp_hdr;

  wvb_rr_arbiter #(
    .N_CHANNELS(N), .P_CHAN_IDX_WIDTH(CW), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .prio_mode(prio_mode), .chan_mask(chan_mask),
    .wvb_hdr_empty(wvb_hdr_empty), .wvb_hdr_data(wvb_hdr_data), .wvb_data(wvb_data),
    .wvb_hdr_rdreq(wvb_hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .out_hdr_valid(out_hdr_valid), .out_hdr_data(out_hdr_data), .out_data(out_data),
    .out_rdreq(out_rdreq), .out_rddone(out_rddone), .busy(busy), .cur_chan(cur_chan),
    .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] hdr_of(input int ch, input int seq);
    return {8'(32'hA0 + ch), 64'(seq), 8'(ch)};
  endfunction

  function automatic logic [DW-1:0] data_of(input int ch);
    return {2'b10, 8'(ch), 32'(32'hC0FFEE00 + ch), 128'(ch * 1000 + 7)};
  endfunction

  function automatic logic [N-1:0] oh(input int ch);
    logic [N-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Show-ahead FIFO model: header content is indexed by how many pops the channel has seen.
  always_comb begin
    for (int ch = 0; ch < N; ch++) begin
      wvb_hdr_empty[ch]         = (pushed[ch] == popped[ch]);
      wvb_hdr_data[ch*HW +: HW] = hdr_of(ch, popped[ch]);
      wvb_data[ch*DW +: DW]     = data_of(ch);
    end
  end

  always @(posedge clk) begin
    for (int ch = 0; ch < N; ch++)
      if (wvb_hdr_rdreq[ch]) popped[ch] <= popped[ch] + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot0(wvb_hdr_rdreq)) begin
      errors++; $display("FAIL hdr_rdreq_onehot: got %h want one-hot or zero", wvb_hdr_rdreq);
    end
  endtask

  // From IDLE with a pending request: decision edge, HDR cycle, then header visible.
  task automatic grant(input int ch, input int seq);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy ch%0d: got %b want 1", ch, busy); end
    checks++; if (cur_chan !== CW'(ch)) begin errors++; $display("FAIL grant_cur_chan: got %0d want %0d", cur_chan, ch); end
    checks++; if (wvb_hdr_rdreq !== oh(ch)) begin errors++; $display("FAIL grant_hdr_rdreq ch%0d: got %h want %h", ch, wvb_hdr_rdreq, oh(ch)); end
    checks++; if (out_hdr_valid !== 1'b0) begin errors++; $display("FAIL grant_early_valid ch%0d: got %b want 0", ch, out_hdr_valid); end
    out_rdreq = 1'b1; out_rddone = 1'b1;
    #1;
    checks++; if ((wvb_rdreq | wvb_rddone) !== '0) begin errors++; $display("FAIL hdr_ignores_consumer: got rdreq %h rddone %h want 0", wvb_rdreq, wvb_rddone); end
    out_rdreq = 1'b0; out_rddone = 1'b0;
    tick();
    last_exp_hdr = {CW'(ch), hdr_of(ch, seq)};
    checks++; if (out_hdr_valid !== 1'b1) begin errors++; $display("FAIL hdr_valid ch%0d: got %b want 1", ch, out_hdr_valid); end
    checks++; if (out_hdr_data !== last_exp_hdr) begin errors++; $display("FAIL hdr_data ch%0d: got %h want %h", ch, out_hdr_data, last_exp_hdr); end
    checks++; if (wvb_hdr_rdreq !== '0) begin errors++; $display("FAIL hdr_rdreq_pulse ch%0d: got %h want 0", ch, wvb_hdr_rdreq); end
  endtask

  // Consumer side of one event in XFER: one data read, then done.
  task automatic consume(input int ch);
    out_rdreq = 1'b1;
    #1;
    checks++; if (wvb_rdreq !== oh(ch)) begin errors++; $display("FAIL xfer_rdreq ch%0d: got %h want %h", ch, wvb_rdreq, oh(ch)); end
    checks++; if (out_data !== data_of(ch)) begin errors++; $display("FAIL xfer_data ch%0d: got %h want %h", ch, out_data, data_of(ch)); end
    tick();
    out_rdreq = 1'b0; out_rddone = 1'b1;
    #1;
    checks++; if (wvb_rddone !== oh(ch)) begin errors++; $display("FAIL xfer_rddone ch%0d: got %h want %h", ch, wvb_rddone, oh(ch)); end
    checks++; if (wvb_rdreq !== '0) begin errors++; $display("FAIL xfer_rdreq_off ch%0d: got %h want 0", ch, wvb_rdreq); end
    tick();
    out_rddone = 1'b0;
    exp_evt++;
    checks++; if (busy !== 1'b0 || out_hdr_valid !== 1'b0) begin errors++; $display("FAIL done_idle ch%0d: got busy %b valid %b want 0 0", ch, busy, out_hdr_valid); end
    checks++; if (evt_cnt !== CNTW'(exp_evt)) begin errors++; $display("FAIL evt_cnt ch%0d: got %0d want %0d", ch, evt_cnt, exp_evt); end
    checks++; if (out_hdr_data !== last_exp_hdr) begin errors++; $display("FAIL hdr_hold ch%0d: got %h want %h", ch, out_hdr_data, last_exp_hdr); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || out_hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_busy_valid: got %b %b want 0 0", busy, out_hdr_valid); end
    checks++; if (out_hdr_data !== '0) begin errors++; $display("FAIL reset_hdr_data: got %h want 0", out_hdr_data); end
    checks++; if (cur_chan !== '0 || evt_cnt !== '0) begin errors++; $display("FAIL reset_chan_cnt: got %0d %0d want 0 0", cur_chan, evt_cnt); end
    checks++; if ((wvb_hdr_rdreq | wvb_rdreq | wvb_rddone) !== '0) begin errors++; $display("FAIL reset_reqs: got %h %h %h want 0", wvb_hdr_rdreq, wvb_rdreq, wvb_rddone); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_same_cycle_pair();
    pushed[5]++; pushed[23]++;
    grant(5, 0); consume(5);
    grant(23, 0); consume(23);
    checks++; if (evt_cnt !== CNTW'(2)) begin errors++; $display("FAIL pair_evt_cnt: got %0d want 2", evt_cnt); end
    checks++; if (popped[5] !== 1 || popped[23] !== 1) begin errors++; $display("FAIL pair_pop_count: got %0d %0d want 1 1", popped[5], popped[23]); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pair_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 3; c++) pushed[c] += 3;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        grant(c, r); consume(c);
      end
  endtask

  task automatic test_fixed_priority();
    prio_mode = 1'b1;
    pushed[0] += 4; pushed[3] += 1;
    for (int s = 3; s < 7; s++) begin
      grant(0, s); consume(0);
    end
    grant(3, 0); consume(3);
    prio_mode = 1'b0;
  endtask

  task automatic test_mask();
    logic [N-1:0] m;
    m = '1; m[5] = 1'b0;
    chan_mask = m;
    pushed[5]++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (busy !== 1'b0 || wvb_hdr_rdreq !== '0) begin errors++; $display("FAIL mask_blocks: got busy %b rdreq %h want 0 0", busy, wvb_hdr_rdreq); end
    end
    chan_mask = '1;
    grant(5, 1); consume(5);
  endtask

  task automatic test_reset_mid_xfer();
    pushed[23]++;
    grant(23, 1);
    out_rdreq = 1'b1;
    #1;
    checks++; if (wvb_rdreq !== oh(23)) begin errors++; $display("FAIL rstx_rdreq_before: got %h want %h", wvb_rdreq, oh(23)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || out_hdr_valid !== 1'b0) begin errors++; $display("FAIL rstx_busy_valid: got %b %b want 0 0", busy, out_hdr_valid); end
    checks++; if (evt_cnt !== '0) begin errors++; $display("FAIL rstx_evt_cnt: got %0d want 0", evt_cnt); end
    checks++; if (wvb_rdreq !== '0) begin errors++; $display("FAIL rstx_rdreq: got %h want 0", wvb_rdreq); end
    out_rdreq = 1'b0;
    exp_evt = 0;
    pushed[0]++; pushed[23]++;
    grant(0, 7); consume(0);
    grant(23, 2); consume(23);
  endtask

  task automatic test_en_drop();
    pushed[1] += 2;
    grant(1, 3);
    en = 1'b0;
    consume(1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (busy !== 1'b0 || wvb_hdr_rdreq !== '0) begin errors++; $display("FAIL en_low_no_grant: got busy %b rdreq %h want 0 0", busy, wvb_hdr_rdreq); end
    end
    en = 1'b1;
    grant(1, 4); consume(1);
  endtask

  initial begin
    for (int ch = 0; ch < N; ch++) begin
      pushed[ch] = 0;
      popped[ch] = 0;
    end
    rst = 1'b1; en = 1'b1; prio_mode = 1'b0; chan_mask = '1;
    out_rdreq = 1'b0; out_rddone = 1'b0;
    last_exp_hdr = '0;
    test_reset();
    test_same_cycle_pair();
    test_round_robin();
    test_fixed_priority();
    test_mask();
    test_reset_mid_xfer();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
